load_store_unit: RTL



---
 rtl/load_store_unit.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide data_memory: splits straddling
// accesses, merges sub-word stores by read-modify-write, and extends load data.
module load_store_unit #(
   parameter int MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [3:0]  req_mode,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_fault,
   output logic [31:0] resp_rdata,
   output logic        memory_read,
   output logic        memory_write,
   output logic [3:0]  memory_mode,
   output logic [31:0] address,
   output logic [31:0] write_data,
   input  logic [31:0] read_data
);

   // Handshake: a request is taken when req_valid && req_ready at a posedge;
   // resp_valid is a single-cycle pulse with no backpressure.

   localparam logic [3:0] M_BYTE  = 4'd0;
   localparam logic [3:0] M_HALF  = 4'd1;
   localparam logic [3:0] M_WORD  = 4'd2;
   localparam logic [3:0] M_UBYTE = 4'd3;
   localparam logic [3:0] M_UHALF = 4'd4;

   typedef enum logic [2:0] {
      IDLE, LD_LO, LD_HI, ST_RD_LO, ST_WR_LO, ST_RD_HI, ST_WR_HI, RESP
   } state_t;

   state_t state, next_state;

   logic        write_q, fault_q;
   logic [3:0]  mode_q;
   logic [31:0] addr_q, wdata_q;
   logic [31:0] lo_q, hi_q;

   function automatic logic [2:0] size_of(input logic [3:0] m);
      case (m)
         M_BYTE, M_UBYTE: size_of = 3'd1;
         M_HALF, M_UHALF: size_of = 3'd2;
         default:         size_of = 3'd4;
      endcase
   endfunction

   // Request-side decode, used only at accept time
   logic        accept;
   logic [2:0]  in_size;
   logic        in_split, in_fault;
   logic [31:0] in_word;

   assign accept   = req_valid && req_ready;
   assign in_size  = size_of(req_mode);
   assign in_split = ({1'b0, req_addr[1:0]} + in_size) > 3'd4;
   assign in_word  = {2'b00, req_addr[31:2]};
   assign in_fault = (req_mode > M_UHALF)
                   || (req_write && (req_mode == M_UBYTE || req_mode == M_UHALF))
                   || (in_word >= 32'(MEM_WORDS))
                   || (in_split && (in_word + 32'd1 >= 32'(MEM_WORDS)));

   // Latched-request decode
   logic [1:0]  off;
   logic [2:0]  size;
   logic        split;
   logic [31:0] word_lo, word_hi;
   logic [5:0]  shamt;

   assign off     = addr_q[1:0];
   assign size    = size_of(mode_q);
   assign split   = ({1'b0, off} + size) > 3'd4;
   assign word_lo = {2'b00, addr_q[31:2]};
   assign word_hi = word_lo + 32'd1;
   assign shamt   = {1'b0, off, 3'b000};

   // Merge: only bytes off .. off+size-1 of {hi,lo} take store data
   logic [3:0]  size_mask;
   logic [7:0]  byte_mask;
   logic [63:0] bit_mask, store_data, merged, extracted;

   always_comb begin
      case (size)
         3'd1:    size_mask = 4'h1;
         3'd2:    size_mask = 4'h3;
         default: size_mask = 4'hf;
      endcase
      byte_mask = {4'h0, size_mask} << off;
      bit_mask  = '0;
      for (int i = 0; i < 8; i++) bit_mask[i*8 +: 8] = {8{byte_mask[i]}};
      store_data = {32'h0, wdata_q} << shamt;
      merged     = ({hi_q, lo_q} & ~bit_mask) | (store_data & bit_mask);
      extracted  = {hi_q, lo_q} >> shamt;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (in_fault)                                     next_state = RESP;
               else if (!req_write)                              next_state = LD_LO;
               else if (req_mode == M_WORD && req_addr[1:0] == 2'd0) next_state = ST_WR_LO;
               else                                              next_state = ST_RD_LO;
            end
         end
         LD_LO:    next_state = split ? LD_HI : RESP;
         LD_HI:    next_state = RESP;
         ST_RD_LO: next_state = ST_WR_LO;
         ST_WR_LO: next_state = split ? ST_RD_HI : RESP;
         ST_RD_HI: next_state = ST_WR_HI;
         ST_WR_HI: next_state = RESP;
         RESP:     next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Request latch and read-data capture
   always_ff @(posedge clk) begin
      if (reset) begin
         write_q <= 1'b0;
         fault_q <= 1'b0;
         mode_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
      end else begin
         if (accept) begin
            write_q <= req_write;
            fault_q <= in_fault;
            mode_q  <= req_mode;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (state == LD_LO || state == ST_RD_LO) lo_q <= read_data;
         if (state == LD_HI || state == ST_RD_HI) hi_q <= read_data;
      end
   end

   // Output logic; everything held at 0 while reset is asserted
   always_comb begin
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      resp_fault   = 1'b0;
      resp_rdata   = '0;
      memory_read  = 1'b0;
      memory_write = 1'b0;
      memory_mode  = '0;
      address      = '0;
      write_data   = '0;
      if (!reset) begin
         memory_mode = M_WORD;
         case (state)
            IDLE: req_ready = 1'b1;
            LD_LO, ST_RD_LO: begin
               memory_read = 1'b1;
               address     = word_lo;
            end
            LD_HI, ST_RD_HI: begin
               memory_read = 1'b1;
               address     = word_hi;
            end
            ST_WR_LO: begin
               memory_write = 1'b1;
               address      = word_lo;
               write_data   = merged[31:0];
            end
            ST_WR_HI: begin
               memory_write = 1'b1;
               address      = word_hi;
               write_data   = merged[63:32];
            end
            RESP: begin
               resp_valid = 1'b1;
               resp_fault = fault_q;
               if (!fault_q && !write_q) begin
                  case (mode_q)
                     M_BYTE:  resp_rdata = {{24{extracted[7]}}, extracted[7:0]};
                     M_HALF:  resp_rdata = {{16{extracted[15]}}, extracted[15:0]};
                     M_UBYTE: resp_rdata = {24'h0, extracted[7:0]};
                     M_UHALF: resp_rdata = {16'h0, extracted[15:0]};
                     default: resp_rdata = extracted[31:0];
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule
